// File: rtl/register_pipe.sv
// Elastic pipeline register: DEPTH valid/ready stages in series. An empty stage
// always accepts, so a stalled output lets upstream stages fill (bubbles collapse).
module register_pipe #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH:0]   w_rdy;
  logic             w_in_xfer;
  logic             w_out_xfer;

  // Ready ripples back from the output; a stage is ready if empty or its successor is ready.
  always_comb begin
    w_rdy[DEPTH] = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      w_rdy[i] = ~r_v[i] | w_rdy[i+1];
    end
  end

  always_comb begin
    w_in_xfer  = in_valid & in_ready;
    w_out_xfer = r_v[DEPTH-1] & out_ready;
  end

  // Stage shift; data is only written when a valid word moves in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_d[i] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_v[0] <= in_valid;
        if (in_valid) begin
          r_d[0] <= in_data;
        end
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (w_rdy[i]) begin
          r_v[i] <= r_v[i-1];
          if (r_v[i-1]) begin
            r_d[i] <= r_d[i-1];
          end
        end
      end
    end
  end

  // Occupancy tracks popcount of the valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = w_rdy[0] & ~flush;
  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_d[DEPTH-1];
  assign count     = r_count;

endmodule

// File: tb/tb_register_pipe.sv
// Directed bench for register_pipe (WIDTH=8, DEPTH=3) with hand-computed expectations.
module tb_register_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned CW = $clog2(D + 1);

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] count;

  int n_vec;
  int n_bad;

  register_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply inputs for one cycle and move to the sampling point (falling edge).
  task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_v;
    int exp_cnt;
    logic [W-1:0] exp_d [3];
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_count", 32'(count), 0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    adv();

    // Streaming 0x01..0x0A with out_ready held high
    for (int c = 0; c < 15; c++) begin
      drive(c < 10, W'(c + 1), 1'b1, 1'b0);
      chk("stream_in_ready", 32'(in_ready), 1);
      exp_v = (c >= 3 && c < 13) ? 1 : 0;
      chk("stream_out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v == 1) chk("stream_out_data", 32'(out_data), 32'(c - 2));
      exp_cnt = ((c < 10) ? c : 10) - ((c < 3) ? 0 : (((c < 13) ? c : 13) - 3));
      chk("stream_count", 32'(count), 32'(exp_cnt));
      adv();
    end

    // Backpressure fill
    drive(1'b1, 8'hA1, 1'b0, 1'b0); chk("bp_rdy0", 32'(in_ready), 1); adv();
    drive(1'b1, 8'hA2, 1'b0, 1'b0); chk("bp_rdy1", 32'(in_ready), 1); adv();
    drive(1'b1, 8'hA3, 1'b0, 1'b0); chk("bp_rdy2", 32'(in_ready), 1); adv();
    for (int c = 0; c < 2; c++) begin
      drive(1'b1, 8'hA4, 1'b0, 1'b0);
      chk("bp_full_rdy", 32'(in_ready), 0);
      chk("bp_full_cnt", 32'(count), 3);
      chk("bp_full_vld", 32'(out_valid), 1);
      chk("bp_full_data", 32'(out_data), 32'hA1);
      adv();
    end
    drive(1'b1, 8'hA4, 1'b1, 1'b0);
    chk("bp_rel_rdy", 32'(in_ready), 1);
    chk("bp_rel_data", 32'(out_data), 32'hA1);
    adv();
    exp_d[0] = 8'hA2; exp_d[1] = 8'hA3; exp_d[2] = 8'hA4;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("bp_drain_vld", 32'(out_valid), 1);
      chk("bp_drain_data", 32'(out_data), 32'(exp_d[c]));
      chk("bp_drain_cnt", 32'(count), 32'(3 - c));
      adv();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bp_empty_vld", 32'(out_valid), 0);
    chk("bp_empty_cnt", 32'(count), 0);
    adv();

    // Bubble collapse
    drive(1'b1, 8'h11, 1'b0, 1'b0); chk("bub_rdy0", 32'(in_ready), 1); adv();
    drive(1'b0, '0, 1'b0, 1'b0); adv();
    drive(1'b0, '0, 1'b0, 1'b0); adv();
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    chk("bub_rdy1", 32'(in_ready), 1);
    chk("bub_vld_a", 32'(out_valid), 1);
    chk("bub_data_a", 32'(out_data), 32'h11);
    chk("bub_cnt_a", 32'(count), 1);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0); chk("bub_cnt_b", 32'(count), 2); adv();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bub_cnt_c", 32'(count), 2);
    chk("bub_data_c", 32'(out_data), 32'h11);
    adv();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bub_vld_d", 32'(out_valid), 1);
    chk("bub_data_d", 32'(out_data), 32'h22);
    chk("bub_cnt_d", 32'(count), 1);
    adv();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("bub_vld_e", 32'(out_valid), 0);
    chk("bub_cnt_e", 32'(count), 0);
    adv();

    // Simultaneous input and output transfer while full
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, W'(8'h31 + c), 1'b0, 1'b0);
      adv();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("sim_full_rdy", 32'(in_ready), 0);
    chk("sim_full_cnt", 32'(count), 3);
    chk("sim_full_data", 32'(out_data), 32'h31);
    adv();
    drive(1'b1, 8'h34, 1'b1, 1'b0);
    chk("sim_both_rdy", 32'(in_ready), 1);
    chk("sim_both_vld", 32'(out_valid), 1);
    chk("sim_both_data", 32'(out_data), 32'h31);
    adv();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("sim_after_cnt", 32'(count), 3);
    chk("sim_after_data", 32'(out_data), 32'h32);
    adv();
    exp_d[0] = 8'h32; exp_d[1] = 8'h33; exp_d[2] = 8'h34;
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("sim_drain_data", 32'(out_data), 32'(exp_d[c]));
      adv();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("sim_empty_vld", 32'(out_valid), 0);
    adv();

    // Flush discards held words and the coincident input
    drive(1'b1, 8'h41, 1'b0, 1'b0); adv();
    drive(1'b1, 8'h42, 1'b0, 1'b0); adv();
    drive(1'b1, 8'h43, 1'b0, 1'b1);
    chk("fl_rdy", 32'(in_ready), 0);
    chk("fl_cnt_before", 32'(count), 2);
    adv();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("fl_vld", 32'(out_valid), 0);
    chk("fl_cnt", 32'(count), 0);
    chk("fl_stale_data", 32'(out_data), 32'h34);
    adv();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("fl_no_word", 32'(out_valid), 0);
      adv();
    end

    // Asynchronous reset mid-stream
    drive(1'b1, 8'h51, 1'b0, 1'b0); adv();
    drive(1'b1, 8'h52, 1'b0, 1'b0); adv();
    drive(1'b0, '0, 1'b0, 1'b0); adv();
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("ar_pre_cnt", 32'(count), 2);
    chk("ar_pre_vld", 32'(out_valid), 1);
    chk("ar_pre_data", 32'(out_data), 32'h51);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_vld", 32'(out_valid), 0);
    chk("ar_data", 32'(out_data), 0);
    chk("ar_cnt", 32'(count), 0);
    @(negedge clk);
    reset = 1'b0;
    adv();
    drive(1'b1, 8'h55, 1'b1, 1'b0);
    chk("ar_new_rdy", 32'(in_ready), 1);
    adv();
    for (int c = 1; c < 3; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      chk("ar_lat_vld", 32'(out_valid), 0);
      adv();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("ar_out_vld", 32'(out_valid), 1);
    chk("ar_out_data", 32'(out_data), 32'h55);
    chk("ar_out_cnt", 32'(count), 1);
    adv();
    drive(1'b0, '0, 1'b1, 1'b0);
    chk("ar_end_vld", 32'(out_valid), 0);
    adv();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
